// File: rtl/uc_booth_pkg.sv
// uc_booth_pkg
//   Shared definitions for the Booth multiplier control unit.
//   - N_DEFAULT : default multiplier width / Booth iteration count
//   - state_t   : control FSM state encoding
package uc_booth_pkg;

  localparam int unsigned N_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/uc_booth_contador_iter.sv
// contador_iter
//   Booth iteration down-counter. Loads N, decrements on request and
//   saturates at 0.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous active-low reset (counter returns to N)
//     load  - reload the counter with N
//     dec   - decrement request (ignored at 0)
//     zero  - counter is 0, or reaches 0 with the decrement in flight
import uc_booth_pkg::*;

module contador_iter #(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned W = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [W-1:0] INIT = W'(N);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= INIT;
    end else if (load) begin
      count <= INIT;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Looks ahead through the current decrement so the FSM can leave the
  // last shift cycle directly for DONE.
  assign zero = (count == '0) || (dec && (count == W'(1)));

endmodule

// File: rtl/uc_booth.sv
// uc_booth
//   Control unit for a radix-2 Booth multiplier datapath (A:Q:Q-1, M).
//   Optional macro: UC_BOOTH_FASTSHIFT_EN -- in EVAL with {q0,qsub1} of
//   00/11 the shift is issued immediately and SHIFT is skipped.
//   Ports:
//     clk      - clock, rising edge
//     reset    - asynchronous active-low reset
//     start    - operation request, sampled only in IDLE
//     q0       - Q register LSB
//     qsub1    - Q-1 bit
//     CargaA   - load adder result into A
//     CargaQ   - load multiplier into Q
//     CargaM   - load multiplicand into M
//     clrA     - clear A and Q-1
//     desplaza - arithmetic right shift of A:Q:Q-1
//     resta    - adder mode (1 = A-M, 0 = A+M)
//     fin      - result valid in A:Q
import uc_booth_pkg::*;

module uc_booth #(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic qsub1,
  output logic CargaA,
  output logic CargaQ,
  output logic CargaM,
  output logic clrA,
  output logic desplaza,
  output logic resta,
  output logic fin
);

  state_t state, next;
  logic   cnt_zero;

  contador_iter #(.N(N)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (state == LOAD),
    .dec  (desplaza),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  // Output decode kept apart from next-state logic: next-state depends on
  // cnt_zero, which in turn depends on desplaza.
  always_comb begin
    CargaA   = 1'b0;
    CargaQ   = 1'b0;
    CargaM   = 1'b0;
    clrA     = 1'b0;
    desplaza = 1'b0;
    resta    = 1'b0;
    fin      = 1'b0;
    case (state)
      LOAD: begin
        CargaQ = 1'b1;
        CargaM = 1'b1;
        clrA   = 1'b1;
      end
      EVAL: begin
        case ({q0, qsub1})
          2'b01:   CargaA = 1'b1;
          2'b10: begin
            CargaA = 1'b1;
            resta  = 1'b1;
          end
          default: begin
`ifdef UC_BOOTH_FASTSHIFT_EN
            desplaza = 1'b1;
`endif
          end
        endcase
      end
      SHIFT:   desplaza = 1'b1;
      DONE:    fin      = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (start) next = LOAD;
      LOAD: next = EVAL;
      EVAL: begin
`ifdef UC_BOOTH_FASTSHIFT_EN
        if (q0 == qsub1) next = cnt_zero ? DONE : EVAL;
        else             next = SHIFT;
`else
        next = SHIFT;
`endif
      end
      SHIFT: next = cnt_zero ? DONE : EVAL;
      DONE:  if (!start) next = IDLE;
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uc_booth.sv
module tb_uc_booth;

  logic clk = 1'b0;
  logic reset, start, q0, qsub1;
  logic CargaA, CargaQ, CargaM, clrA, desplaza, resta, fin;

  logic drv_q0, drv_qsub1, use_dp;
  logic [2:0] mult_in, mcand_in;
  logic [2:0] dp_a = '0, dp_q = '0, dp_m = '0;
  logic       dp_qm1 = 1'b0;

  logic [6:0] outs;
  assign outs  = {CargaA, CargaQ, CargaM, clrA, desplaza, resta, fin};
  assign q0    = use_dp ? dp_q[0] : drv_q0;
  assign qsub1 = use_dp ? dp_qm1  : drv_qsub1;

  localparam logic [6:0] O_Z  = 7'b0000000;
  localparam logic [6:0] O_LD = 7'b0111000;
  localparam logic [6:0] O_SH = 7'b0000100;
  localparam logic [6:0] O_AD = 7'b1000000;
  localparam logic [6:0] O_SB = 7'b1000010;
  localparam logic [6:0] O_FN = 7'b0000001;

  typedef struct {
    logic [6:0] v;
    int         sc;
    int         cy;
  } exp_t;

  exp_t       out_q[$];
  logic [5:0] prod_q[$];
  int tests = 0;
  int fails = 0;
  int sc_id = 0;
  int cy_id = 0;
  logic fin_d = 1'b0;

  uc_booth #(.N(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q0      (q0),
    .qsub1   (qsub1),
    .CargaA  (CargaA),
    .CargaQ  (CargaQ),
    .CargaM  (CargaM),
    .clrA    (clrA),
    .desplaza(desplaza),
    .resta   (resta),
    .fin     (fin)
  );

  always #5 clk = ~clk;

  // Reference datapath, 3-bit signed operands
  always @(posedge clk) begin
    if (clrA) begin
      dp_a   <= '0;
      dp_qm1 <= 1'b0;
    end
    if (CargaQ) dp_q <= mult_in;
    if (CargaM) dp_m <= mcand_in;
    if (CargaA) dp_a <= resta ? (dp_a - dp_m) : (dp_a + dp_m);
    if (desplaza) {dp_a, dp_q, dp_qm1} <= {dp_a[2], dp_a, dp_q};
  end

  // Monitor: pops expected per-cycle outputs and products at fin rise
  always @(negedge clk) begin
    exp_t x;
    logic [5:0] p;
    if (out_q.size() > 0) begin
      x = out_q.pop_front();
      tests++;
      if (outs !== x.v) begin
        fails++;
        $display("FAIL outs s%0d c%0d got %b want %b", x.sc, x.cy, outs, x.v);
      end
    end
    tests++;
    if ((CargaA && desplaza) || (resta && !CargaA)) begin
      fails++;
      $display("FAIL excl got %b want no CargaA+desplaza, no resta without CargaA", outs);
    end
    if (fin && !fin_d && prod_q.size() > 0) begin
      p = prod_q.pop_front();
      tests++;
      if ({dp_a, dp_q} !== p) begin
        fails++;
        $display("FAIL product got %b want %b", {dp_a, dp_q}, p);
      end
    end
    fin_d = fin;
  end

  task automatic new_sc(input int id);
    sc_id = id;
    cy_id = 0;
  endtask

  task automatic step(input logic rst, input logic st, input logic a,
                      input logic b, input logic [6:0] e);
    exp_t x;
    @(posedge clk); #1;
    reset     = rst;
    start     = st;
    drv_q0    = a;
    drv_qsub1 = b;
    x.v  = e;
    x.sc = sc_id;
    x.cy = cy_id;
    out_q.push_back(x);
    cy_id++;
  endtask

  task automatic run_mult(input logic [2:0] mr, input logic [2:0] md,
                          input logic [5:0] p);
    bit got;
    @(posedge clk); #1;
    use_dp   = 1'b1;
    mult_in  = mr;
    mcand_in = md;
    start    = 1'b1;
    prod_q.push_back(p);
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int unsigned i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (fin) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL fin_timeout got fin=0 want fin=1 for %b*%b", mr, md);
      prod_q.delete();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    use_dp = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; drv_q0 = 1'b0; drv_qsub1 = 1'b0;
    use_dp = 1'b0; mult_in = '0; mcand_in = '0;
    repeat (2) @(posedge clk);

    new_sc(0);
    step(0, 1, 0, 0, O_Z);   // start ignored under reset
    step(1, 0, 0, 0, O_Z);

`ifndef UC_BOOTH_FASTSHIFT_EN
    // 00 held: shifts on cycles 3,5,7, fin at 8
    new_sc(1);
    step(1, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_LD);
    step(1, 0, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 0, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 0, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 0, 0, 0, O_FN); step(1, 0, 0, 0, O_Z);

    // 10 then 01 then 11 in successive EVALs
    new_sc(2);
    step(1, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_LD);
    step(1, 0, 1, 0, O_SB); step(1, 0, 1, 0, O_SH);
    step(1, 0, 0, 1, O_AD); step(1, 0, 0, 1, O_SH);
    step(1, 0, 1, 1, O_Z);  step(1, 0, 1, 1, O_SH);
    step(1, 0, 0, 0, O_FN); step(1, 0, 0, 0, O_Z);

    // reset during SHIFT, then full restart with counter back at 3
    new_sc(3);
    step(1, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_LD);
    step(1, 0, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 0, 0, 0, O_Z);  step(0, 0, 0, 0, O_Z);
    step(0, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_Z);
    step(1, 0, 0, 0, O_Z);
    step(1, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_LD);
    step(1, 0, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 0, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 0, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 0, 0, 0, O_FN); step(1, 0, 0, 0, O_Z);

    // start toggled mid-run, held through DONE, then released
    new_sc(4);
    step(1, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_LD);
    step(1, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_SH);
    step(1, 1, 0, 0, O_Z);  step(1, 1, 0, 0, O_SH);
    step(1, 0, 0, 0, O_Z);  step(1, 1, 0, 0, O_SH);
    step(1, 1, 0, 0, O_FN); step(1, 1, 0, 0, O_FN);
    step(1, 0, 0, 0, O_FN); step(1, 0, 0, 0, O_Z);
    step(1, 0, 0, 0, O_Z);
`else
    // 11 held: shifts on cycles 2,3,4, fin at 5
    new_sc(5);
    step(1, 1, 1, 1, O_Z);  step(1, 0, 1, 1, O_LD);
    step(1, 0, 1, 1, O_SH); step(1, 0, 1, 1, O_SH);
    step(1, 0, 1, 1, O_SH); step(1, 0, 1, 1, O_FN);
    step(1, 0, 1, 1, O_Z);

    // 10, 01 take the SHIFT state; 11 shifts in EVAL
    new_sc(6);
    step(1, 1, 0, 0, O_Z);  step(1, 0, 0, 0, O_LD);
    step(1, 0, 1, 0, O_SB); step(1, 0, 1, 0, O_SH);
    step(1, 0, 0, 1, O_AD); step(1, 0, 0, 1, O_SH);
    step(1, 0, 1, 1, O_SH); step(1, 0, 0, 0, O_FN);
    step(1, 0, 0, 0, O_Z);
`endif

    // End-to-end products with the reference datapath
    run_mult(3'b110, 3'b011, 6'b111010);  // -2 *  3 = -6
    run_mult(3'b011, 3'b011, 6'b001001);  //  3 *  3 =  9
    run_mult(3'b100, 3'b011, 6'b110100);  // -4 *  3 = -12
    run_mult(3'b011, 3'b101, 6'b110111);  //  3 * -3 = -9

    step(1, 0, 0, 0, O_Z);
    @(negedge clk); #1;
    tests++;
    if (out_q.size() != 0 || prod_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d/%0d pending want 0/0", out_q.size(), prod_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
